// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states
// and default datapath sizes.
package regfile_sequencer_pkg;

    localparam int N_DEF  = 4;
    localparam int AW_DEF = 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_LDI = 3'd6,
        OP_CMP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    // CMP only produces flags; every other op commits its result.
    function automatic logic op_writes(input op_e op);
        return (op != OP_CMP);
    endfunction

endpackage

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU for the sequencer: result, carry/borrow, zero flag and
// whether the op should write the register file.
module rf_alu
    import regfile_sequencer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  op_e          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] imm,
    output logic [N-1:0] res,
    output logic         carry,
    output logic         zero,
    output logic         wr_en
);

    logic [N:0] ext;

    // ADD/SUB/CMP share one (N+1)-bit adder path; the top bit is carry or borrow.
    always_comb begin
        ext   = '0;
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                res   = ext[N-1:0];
                carry = ext[N];
            end
            OP_SUB, OP_CMP: begin
                ext   = {1'b0, a} - {1'b0, b};
                res   = ext[N-1:0];
                carry = ext[N];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOV:  res = a;
            OP_LDI:  res = imm;
            default: res = '0;
        endcase
    end

    assign zero  = (res == '0);
    assign wr_en = op_writes(op);

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the two-entry register file: accepts one
// command, reads two sources, runs the ALU and writes the result back.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_da,
    input  logic [AW-1:0] cmd_sa,
    input  logic [AW-1:0] cmd_sb,
    input  logic [N-1:0]  cmd_imm,
    output logic [AW-1:0] SA,
    output logic [AW-1:0] SB,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    output logic [AW-1:0] DA,
    output logic [N-1:0]  D,
    output logic          W,
    output logic          res_valid,
    output logic [N-1:0]  res_data,
    output logic          res_carry,
    output logic          res_zero
);

    state_e        state;
    op_e           op_q;
    logic [AW-1:0] da_q;
    logic [N-1:0]  imm_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;

    logic [N-1:0]  alu_res;
    logic          alu_carry;
    logic          alu_zero;
    logic          alu_wr_en;

    assign cmd_ready = (state == IDLE) && !rst;

    rf_alu #(.N(N)) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .imm   (imm_q),
        .res   (alu_res),
        .carry (alu_carry),
        .zero  (alu_zero),
        .wr_en (alu_wr_en)
    );

    // Results are loaded on the edge leaving EXEC so W/D/res_* are all valid
    // throughout WRITE, and the file commits on the edge leaving WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            da_q      <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            SA        <= '0;
            SB        <= '0;
            DA        <= '0;
            D         <= '0;
            W         <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
        end else begin
            W         <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q  <= op_e'(cmd_op);
                        da_q  <= cmd_da;
                        imm_q <= cmd_imm;
                        SA    <= cmd_sa;
                        SB    <= cmd_sb;
                        state <= READ;
                    end
                end
                READ: begin
                    a_q   <= A;
                    b_q   <= B;
                    state <= EXEC;
                end
                EXEC: begin
                    W         <= alu_wr_en;
                    DA        <= da_q;
                    D         <= alu_res;
                    res_valid <= 1'b1;
                    res_data  <= alu_res;
                    res_carry <= alu_carry;
                    res_zero  <= alu_zero;
                    state     <= WRITE;
                end
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: models the register file around the sequencer and
// checks each command against a behavioural reference of the ALU rules.
module tb_regfile_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_da;
    logic       cmd_sa;
    logic       cmd_sb;
    logic [3:0] cmd_imm;
    logic       SA;
    logic       SB;
    logic [3:0] A;
    logic [3:0] B;
    logic       DA;
    logic [3:0] D;
    logic       W;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;

    logic [3:0] rf [0:1];
    int         exp_rf [0:1];
    int         total = 0;
    int         bad = 0;

    regfile_sequencer #(.N(4), .AW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_da    (cmd_da),
        .cmd_sa    (cmd_sa),
        .cmd_sb    (cmd_sb),
        .cmd_imm   (cmd_imm),
        .SA        (SA),
        .SB        (SB),
        .A         (A),
        .B         (B),
        .DA        (DA),
        .D         (D),
        .W         (W),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational reads, write on the rising edge.
    assign A = rf[SA];
    assign B = rf[SB];
    always @(posedge clk) begin
        if (rst) begin
            rf[0] <= 4'h0;
            rf[1] <= 4'h0;
        end else if (W) begin
            rf[DA] <= D;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void ref_op(input int op, input int a, input int b, input int imm,
                                   output int res, output int cy, output int wr);
        cy  = 0;
        wr  = (op != 7) ? 1 : 0;
        case (op)
            0: begin res = (a + b) % 16; cy = (a + b > 15) ? 1 : 0; end
            1, 7: begin res = (a - b + 16) % 16; cy = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = a;
            6: res = imm;
            default: res = 0;
        endcase
    endfunction

    task automatic do_cmd(input int op, input int da, input int sa, input int sb, input int imm);
        int er, ec, ew, ez, n;
        ref_op(op, exp_rf[sa], exp_rf[sb], imm, er, ec, ew);
        ez = (er == 0) ? 1 : 0;
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_da    = 1'(da);
        cmd_sa    = 1'(sa);
        cmd_sb    = 1'(sb);
        cmd_imm   = 4'(imm);
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!cmd_ready) begin
            bad++;
            $display("[TB] FAIL accept_timeout op=%0d: cmd_ready got %b required 1", op, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if ({cmd_ready, SA, SB, W, res_valid} !== {1'b0, 1'(sa), 1'(sb), 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL read_phase op=%0d: got %b required %b", op,
                     {cmd_ready, SA, SB, W, res_valid}, {1'b0, 1'(sa), 1'(sb), 1'b0, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({cmd_ready, W, res_valid} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL exec_phase op=%0d: got %b required 000", op, {cmd_ready, W, res_valid});
        end
        @(negedge clk);
        total++;
        if ({W, DA, res_valid, res_data, res_carry, res_zero} !==
            {1'(ew), 1'(da), 1'b1, 4'(er), 1'(ec), 1'(ez)}) begin
            bad++;
            $display("[TB] FAIL write_phase op=%0d: got %h required %h", op,
                     {W, DA, res_valid, res_data, res_carry, res_zero},
                     {1'(ew), 1'(da), 1'b1, 4'(er), 1'(ec), 1'(ez)});
        end
        if (ew == 1) begin
            total++;
            if (D !== 4'(er)) begin
                bad++;
                $display("[TB] FAIL write_data op=%0d: D got %h required %h", op, D, 4'(er));
            end
            exp_rf[da] = er;
        end
        @(negedge clk);
        total++;
        if ({cmd_ready, W, res_valid, res_data, res_carry, res_zero, rf[0], rf[1]} !==
            {1'b1, 1'b0, 1'b0, 4'(er), 1'(ec), 1'(ez), 4'(exp_rf[0]), 4'(exp_rf[1])}) begin
            bad++;
            $display("[TB] FAIL after_write op=%0d: got %h required %h", op,
                     {cmd_ready, W, res_valid, res_data, res_carry, res_zero, rf[0], rf[1]},
                     {1'b1, 1'b0, 1'b0, 4'(er), 1'(ec), 1'(ez), 4'(exp_rf[0]), 4'(exp_rf[1])});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cmd_ready, SA, SB, DA, D, W, res_valid, res_data, res_carry, res_zero} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_values: got %h required 0",
                     {cmd_ready, SA, SB, DA, D, W, res_valid, res_data, res_carry, res_zero});
        end
        rst = 1'b0;
        exp_rf[0] = 0;
        exp_rf[1] = 0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_ldi();
        do_cmd(6, 0, 0, 0, 9);
    endtask

    task automatic test_add_carry();
        do_cmd(6, 1, 0, 0, 8);
        do_cmd(0, 0, 0, 1, 0);
    endtask

    task automatic test_sub_cmp();
        do_cmd(1, 1, 1, 1, 0);
        do_cmd(7, 1, 1, 0, 0);
    endtask

    task automatic test_logic();
        for (int op = 2; op <= 5; op++) begin
            do_cmd(6, 0, 0, 0, 12);
            do_cmd(6, 1, 0, 0, 10);
            do_cmd(op, 0, 0, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, r1, r2, cy, wr;
        logic [15:0] rv_obs, rv_exp;
        logic [7:0]  rd_obs;
        first = -1;
        second = -1;
        rv_obs = '0;
        rd_obs = '0;
        ref_op(0, exp_rf[0], exp_rf[1], 0, r1, cy, wr);
        ref_op(0, r1, exp_rf[1], 0, r2, cy, wr);
        cmd_valid = 1'b1;
        cmd_op = 3'd0;
        cmd_da = 1'b0;
        cmd_sa = 1'b0;
        cmd_sb = 1'b1;
        cmd_imm = 4'h0;
        for (int c = 0; c < 16; c++) begin
            rv_obs[c] = res_valid;
            if (res_valid) rd_obs = {rd_obs[3:0], res_data};
            if (first >= 0 && second < 0 && c > first && c < first + 4) begin
                total++;
                if (cmd_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL b2b_busy cycle=%0d: cmd_ready got %b required 0", c, cmd_ready);
                end
            end
            if (cmd_ready && cmd_valid) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            @(posedge clk);
            @(negedge clk);
            if (second >= 0) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        exp_rf[0] = r2;
        rv_exp = '0;
        if (first >= 0 && first + 7 < 16) begin
            rv_exp[first + 3] = 1'b1;
            rv_exp[first + 7] = 1'b1;
        end
        total++;
        if (first < 0 || second - first != 4) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles required 4", second - first);
        end
        total++;
        if ({rv_obs, rd_obs, rf[0]} !== {rv_exp, 4'(r1), 4'(r2), 4'(r2)}) begin
            bad++;
            $display("[TB] FAIL b2b_results: got %h required %h",
                     {rv_obs, rd_obs, rf[0]}, {rv_exp, 4'(r1), 4'(r2), 4'(r2)});
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        cmd_valid = 1'b1;
        cmd_op = 3'd6;
        cmd_da = 1'b0;
        cmd_sa = 1'b0;
        cmd_sb = 1'b0;
        cmd_imm = 4'h5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({cmd_ready, W, res_valid, res_data, res_carry, res_zero} !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got %h required 0",
                     {cmd_ready, W, res_valid, res_data, res_carry, res_zero});
        end
        rst = 1'b0;
        exp_rf[0] = 0;
        exp_rf[1] = 0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_valid || W || !cmd_ready) seen++;
        end
        total++;
        if (seen != 0 || rf[0] !== 4'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid_after: stray cycles got %0d required 0, R0 got %h required 0",
                     seen, rf[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_da = 1'b0;
        cmd_sa = 1'b0;
        cmd_sb = 1'b0;
        cmd_imm = 4'h0;
        @(negedge clk);
        test_reset();
        test_ldi();
        test_add_carry();
        test_sub_cmp();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
